// File: rtl/queue_serializer.sv
// Pops bytes from an upstream queue and shifts each one out MSB-first on a framed serial line.
// Optional even-parity trailer bit per frame when QUEUE_SERIALIZER_PARITY_EN is defined.
`timescale 1ns/1ps

module queue_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clock_10KHZ,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  stall_in,
  output logic                  dequeue_out,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  busy_out,
  output logic [7:0]            byte_count_out
);

`ifdef QUEUE_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = DATA_WIDTH;
`endif
  localparam int unsigned IDX_W   = $clog2(FRAME_BITS);
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned COUNT_W = 8;

  generate
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_range_check
      $error("queue_serializer: GAP_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [COUNT_W-1:0]      cnt_q, cnt_d;
  logic                    deq_d, sout_d, sval_d, busy_d;
  logic [FRAME_BITS-1:0]   frame_load_c;

  // Payload as it enters the shift register; parity rides in the LSB so it shifts out last.
`ifdef QUEUE_SERIALIZER_PARITY_EN
  assign frame_load_c = {data_in, ^data_in};
`else
  assign frame_load_c = data_in;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    deq_d   = 1'b0;
    sout_d  = serial_out;
    sval_d  = serial_valid;
    case (state_q)
      IDLE: begin
        if (len_in != '0 && !stall_in) begin
          sr_d    = frame_load_c;
          deq_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // len_in is stale here: the queue only decrements on this cycle's edge.
        state_d = SHIFT;
        idx_d   = '0;
        sval_d  = 1'b1;
        sout_d  = sr_q[FRAME_BITS-1];
      end
      SHIFT: begin
        if (!stall_in) begin
          if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
            state_d = GAP;
            gap_d   = '0;
            sval_d  = 1'b0;
            sout_d  = 1'b0;
            cnt_d   = cnt_q + COUNT_W'(1);
          end else begin
            sr_d   = sr_q << 1;
            sout_d = sr_q[FRAME_BITS-2];
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock_10KHZ or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      cnt_q          <= '0;
      dequeue_out    <= 1'b0;
      serial_out     <= 1'b0;
      serial_valid   <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      cnt_q          <= cnt_d;
      dequeue_out    <= deq_d;
      serial_out     <= sout_d;
      serial_valid   <= sval_d;
      busy_out       <= busy_d;
    end
  end

  assign byte_count_out = cnt_q;

endmodule

// File: doc/queue_serializer.md
Name: queue_serializer

Overview:
- Downstream consumer of the 8-bit queue in the clock_10KHZ domain.
- Watches the queue occupancy and pops one byte at a time with a single-cycle dequeue pulse.
- Shifts each popped byte out MSB-first on a framed serial line, then inserts a fixed idle gap before the next pop.
- Provides stall (back-pressure), busy status and a sent-byte counter.

Parameters:
- DATA_WIDTH, 8, width of the queue word and of one serial frame payload.
- LEN_WIDTH, 4, width of the queue occupancy input.
- GAP_CYCLES, 2, idle cycles between frames; legal range is 1 to 15, with 0 rejected by an elaboration-time check.

Ports:
- clock_10KHZ  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- len_in  input  LEN_WIDTH  queue occupancy (queue len_out).
- data_in  input  DATA_WIDTH  queue head word (queue data_out); valid whenever len_in != 0.
- stall_in  input  1  downstream back-pressure; 1 freezes shifting.
- dequeue_out  output  1  one-cycle pop pulse to the queue's dequeue_in.
- serial_out  output  1  serial data bit.
- serial_valid  output  1  high while serial_out carries a frame bit.
- busy_out  output  1  high in every state except IDLE.
- byte_count_out  output  8  frames completed, modulo 256.

Behaviour:
- Reset (reset=0, async)
  - All outputs go to 0. State goes to IDLE. Shift register, bit counter and gap counter clear.
  - A frame in flight is abandoned. Its byte was already popped and is lost; this is required behaviour.
- States: IDLE, LOAD, SHIFT, GAP. All outputs are registered.
- IDLE
  - Condition checked at each edge: len_in != 0 and stall_in == 0.
  - When true: capture data_in into the shift register, set dequeue_out, go to LOAD.
  - When false: stay in IDLE.
- LOAD (exactly 1 cycle)
  - dequeue_out is 1 for this cycle only.
  - len_in is ignored here, because the queue has not yet decremented.
  - Next state: SHIFT, bit index 0.
- SHIFT
  - serial_valid = 1; serial_out = current MSB of the shift register.
  - Edge with stall_in == 0: shift left one bit and increment the bit index.
  - Edge with stall_in == 1: hold serial_out, serial_valid and the bit index unchanged.
  - After the last frame bit has been held one unstalled cycle, go to GAP and increment byte_count_out. byte_count_out wraps from 255 to 0.
- GAP
  - serial_valid = 0, serial_out = 0.
  - Count GAP_CYCLES cycles, then go to IDLE. stall_in has no effect in GAP.
- Latency
  - len_in nonzero and stall_in=0 sampled at edge k: dequeue_out is high in cycle k+1, first bit appears in cycle k+2.
  - Unstalled frame with the default parameters and parity off: LOAD, 8 SHIFT cycles, 2 GAP cycles.
  - Back-to-back pops are therefore spaced 1 + DATA_WIDTH + GAP_CYCLES + 1 cycles apart (12 for the defaults).
- Empty queue (len_in == 0): stay in IDLE and never assert dequeue_out.
- stall_in high while in IDLE: no pop.
- The block never issues a second pop before the queue's len update is visible; GAP_CYCLES >= 1 guarantees this.
- serial_out changes only on rising edges.

Optional Feature:
- Macro: QUEUE_SERIALIZER_PARITY_EN.
- Defined:
  - Each frame gets one extra SHIFT bit after the payload: the even parity (XOR) of the DATA_WIDTH payload bits.
  - serial_valid stays high for that bit; stall applies to it.
  - The frame is DATA_WIDTH+1 bits, and byte_count_out increments after the parity bit.
- Undefined: frame is DATA_WIDTH bits, with no parity logic synthesized.

Test Plan:
- Reset check: hold reset=0 with len_in=3 and data_in=8'hA5 -> all outputs 0, no dequeue_out.
- Release reset: dequeue_out is high exactly one cycle later, then serial_out is 1,0,1,0,0,1,0,1 on 8 consecutive cycles with serial_valid=1, then 2 cycles of serial_valid=0, then byte_count_out=1.
- Empty queue: len_in=0 for 50 cycles -> dequeue_out stays 0, busy_out stays 0, serial_valid stays 0.
- Stall mid-frame: data_in=8'hF0 with stall_in=1 for 3 cycles during bit 4 -> bit 4 (value 0) is held 4 cycles total; frame completes with 8 distinct bits 1,1,1,1,0,0,0,0; dequeue_out pulsed once.
- Back-to-back drain: queue model holding 3 bytes (8'h01, 8'h80, 8'hFF) -> exactly 3 dequeue pulses spaced 12 cycles apart, correct bit streams, byte_count_out=3, then idle.
- Reset mid-frame: pull reset low during bit 3 -> outputs go to 0 immediately (asynchronously); after release, the next queued byte is popped and sent intact and byte_count_out restarts at 1.
- Parity with macro defined: data_in=8'h07 -> 9 valid bits 0,0,0,0,0,1,1,1,1, where the last bit is parity 1; with 8'h03 the parity bit is 0.
- Counter wrap: send 256 frames -> byte_count_out wraps from 255 to 0.
